fighter_ctrl: RTL

//  Parametrised per-player fighter controller: frame-ticked movement/attack FSM with
//  hit/block stun, arena clamping and opponent-spacing limit. Emits position, state
//  and mirrored hit/hurt boxes to the collision checker and sprite renderer.

---
 rtl/fighter_pkg.sv | 29 ++
 rtl/fighter_pos_clamp.sv | 63 ++++++
 rtl/fighter_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/fighter_pkg.sv
`default_nettype none
// ============================================================================
// fighter_pkg: state codes and default frame lengths shared by the fighter
// controller, sprite renderer and collision unit.      Rev 1.0
// ============================================================================
package fighter_pkg;

  localparam int STATE_W = 4;
  localparam int FRAME_W = 5;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE        = 4'd0,
    ST_MOVE_FWD    = 4'd1,
    ST_MOVE_BACK   = 4'd2,
    ST_ATK_START   = 4'd3,
    ST_ATK_ACTIVE  = 4'd4,
    ST_ATK_RECOVER = 4'd5,
    ST_HITSTUN     = 4'd6,
    ST_BLOCKSTUN   = 4'd7
  } fighter_state_e;

  localparam int DEF_STARTUP_FR   = 4;
  localparam int DEF_ACTIVE_FR    = 2;
  localparam int DEF_RECOVER_FR   = 15;
  localparam int DEF_HITSTUN_FR   = 12;
  localparam int DEF_BLOCKSTUN_FR = 6;

endpackage
`default_nettype wire

// File: rtl/fighter_pos_clamp.sv
`default_nettype none
// ============================================================================
// fighter_pos_clamp: combinational next-posx (step, opponent gap clip, arena
// clamp). Rev 1.0
// ============================================================================
module fighter_pos_clamp
  import fighter_pkg::*;
#(
  parameter int SIDE    = 0,
  parameter int W       = 10,
  parameter int X_MIN   = 50,
  parameter int X_MAX   = 490,
  parameter int P_SPEED = 15,
  parameter int MIN_GAP = 60
) (
  input  logic [W-1:0] posx_i,
  input  logic [W-1:0] opp_posx_i,
  input  logic         move_fwd_i,
  input  logic         move_back_i,
  input  logic         push_back_i,
  output logic [W-1:0] posx_o
);

  localparam int SW  = W + 2;
  localparam int DIR = (SIDE == 0) ? 1 : -1;

  localparam logic signed [SW-1:0] STEP_FWD  = SW'(DIR * P_SPEED);
  localparam logic signed [SW-1:0] STEP_BACK = SW'(-DIR * P_SPEED);
  localparam logic signed [SW-1:0] STEP_PUSH = SW'(-DIR * 2);
  localparam logic signed [SW-1:0] GAP       = SW'(MIN_GAP);
  localparam logic signed [SW-1:0] LO        = SW'(X_MIN);
  localparam logic signed [SW-1:0] HI        = SW'(X_MAX);

  logic signed [SW-1:0] cur_w, step_w, stepped_w, lim_w, clipped_w, clamped_w;

  always_comb begin
    cur_w = signed'({2'b00, posx_i});
    step_w = '0;
    if (move_fwd_i)       step_w = STEP_FWD;
    else if (move_back_i) step_w = STEP_BACK;
    else if (push_back_i) step_w = STEP_PUSH;
    stepped_w = cur_w + step_w;

    // The gap limit may only stop forward motion, never pull the player back.
    lim_w     = (SIDE == 0) ? (signed'({2'b00, opp_posx_i}) - GAP)
                            : (signed'({2'b00, opp_posx_i}) + GAP);
    clipped_w = stepped_w;
    if (move_fwd_i) begin
      if (SIDE == 0) begin
        if (stepped_w > lim_w) clipped_w = (lim_w > cur_w) ? lim_w : cur_w;
      end else begin
        if (stepped_w < lim_w) clipped_w = (lim_w < cur_w) ? lim_w : cur_w;
      end
    end

    clamped_w = clipped_w;
    if (clipped_w < LO)      clamped_w = LO;
    else if (clipped_w > HI) clamped_w = HI;
    posx_o = W'(clamped_w);
  end

endmodule
`default_nettype wire

// File: rtl/fighter_ctrl.sv
`default_nettype none
// ============================================================================
// fighter_ctrl: per-player movement/attack FSM with hit/block stun, position
// tracking and mirrored hit/hurt boxes.                Rev 1.0
// ============================================================================
module fighter_ctrl
  import fighter_pkg::*;
#(
  parameter int SIDE         = 0,
  parameter int W            = 10,
  parameter int X_INIT       = (SIDE != 0) ? 420 : 210,
  parameter int X_MIN        = 50,
  parameter int X_MAX        = 490,
  parameter int POS_Y        = 170,
  parameter int P_SPEED      = 15,
  parameter int MIN_GAP      = 60,
  parameter int STARTUP_FR   = DEF_STARTUP_FR,
  parameter int ACTIVE_FR    = DEF_ACTIVE_FR,
  parameter int RECOVER_FR   = DEF_RECOVER_FR,
  parameter int HITSTUN_FR   = DEF_HITSTUN_FR,
  parameter int BLOCKSTUN_FR = DEF_BLOCKSTUN_FR,
  parameter int SPRITE_W     = 150,
  parameter int HB_NEAR      = 37,
  parameter int HB_FAR       = 113,
  parameter int HB_Y1        = 24,
  parameter int HB_Y2        = 57,
  parameter int HU_NEAR      = 37,
  parameter int HU_FAR       = 86
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_i,
  input  logic               left_i,
  input  logic               right_i,
  input  logic               attack_i,
  input  logic               hit_in_i,
  input  logic [W-1:0]       opp_posx_i,
  output logic [W-1:0]       posx_o,
  output logic [W-1:0]       posy_o,
  output logic [STATE_W-1:0] current_state_o,
  output logic [FRAME_W-1:0] state_frame_o,
  output logic               hitbox_valid_o,
  output logic [W-1:0]       hitbox_x1_o,
  output logic [W-1:0]       hitbox_x2_o,
  output logic [W-1:0]       hitbox_y1_o,
  output logic [W-1:0]       hitbox_y2_o,
  output logic [W-1:0]       hurtbox_x1_o,
  output logic [W-1:0]       hurtbox_x2_o,
  output logic [W-1:0]       hurtbox_y1_o,
  output logic [W-1:0]       hurtbox_y2_o
);

  localparam logic [FRAME_W-1:0] LAST_STARTUP   = FRAME_W'(STARTUP_FR - 1);
  localparam logic [FRAME_W-1:0] LAST_ACTIVE    = FRAME_W'(ACTIVE_FR - 1);
  localparam logic [FRAME_W-1:0] LAST_RECOVER   = FRAME_W'(RECOVER_FR - 1);
  localparam logic [FRAME_W-1:0] LAST_HITSTUN   = FRAME_W'(HITSTUN_FR - 1);
  localparam logic [FRAME_W-1:0] LAST_BLOCKSTUN = FRAME_W'(BLOCKSTUN_FR - 1);

  // Box offsets from posx; the right-side player mirrors around the sprite width.
  localparam int HB_X1_OFF = (SIDE != 0) ? (SPRITE_W - HB_FAR)  : HB_NEAR;
  localparam int HB_X2_OFF = (SIDE != 0) ? (SPRITE_W - HB_NEAR) : HB_FAR;
  localparam int HU_X1_OFF = (SIDE != 0) ? (SPRITE_W - HU_FAR)  : HU_NEAR;
  localparam int HU_X2_OFF = (SIDE != 0) ? (SPRITE_W - HU_NEAR) : HU_FAR;

  fighter_state_e     state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [W-1:0]       posx_q, posx_next;
  logic               hit_pend_q, hit_pend_d;
  logic               fwd_held, back_held, restart;

  assign fwd_held  = (SIDE == 0) ? right_i : left_i;
  assign back_held = (SIDE == 0) ? left_i  : right_i;

  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    if (hit_pend_q) begin
      restart = 1'b1;
      if ((state_q == ST_MOVE_BACK) || ((state_q == ST_IDLE) && back_held))
        state_d = ST_BLOCKSTUN;
      else
        state_d = ST_HITSTUN;
    end else begin
      case (state_q)
        ST_IDLE, ST_MOVE_FWD, ST_MOVE_BACK: begin
          if (attack_i)                state_d = ST_ATK_START;
          else if (left_i && right_i)  state_d = ST_MOVE_BACK;
          else if (fwd_held)           state_d = ST_MOVE_FWD;
          else if (back_held)          state_d = ST_MOVE_BACK;
          else                         state_d = ST_IDLE;
        end
        ST_ATK_START:   if (frame_q == LAST_STARTUP)   state_d = ST_ATK_ACTIVE;
        ST_ATK_ACTIVE:  if (frame_q == LAST_ACTIVE)    state_d = ST_ATK_RECOVER;
        ST_ATK_RECOVER: if (frame_q == LAST_RECOVER)   state_d = ST_IDLE;
        ST_HITSTUN:     if (frame_q == LAST_HITSTUN)   state_d = ST_IDLE;
        ST_BLOCKSTUN:   if (frame_q == LAST_BLOCKSTUN) state_d = ST_IDLE;
        default:        state_d = ST_IDLE;
      endcase
    end

    if (restart || (state_d != state_q)) frame_d = '0;
    else if (frame_q != '1)              frame_d = frame_q + 1'b1;
    else                                 frame_d = frame_q;
  end

  // A hit arriving on the consuming tick must survive into the next frame.
  assign hit_pend_d = hit_in_i | (hit_pend_q & ~tick_i);

  fighter_pos_clamp #(
    .SIDE    (SIDE),
    .W       (W),
    .X_MIN   (X_MIN),
    .X_MAX   (X_MAX),
    .P_SPEED (P_SPEED),
    .MIN_GAP (MIN_GAP)
  ) u_pos_clamp (
    .posx_i      (posx_q),
    .opp_posx_i  (opp_posx_i),
    .move_fwd_i  (state_q == ST_MOVE_FWD),
    .move_back_i (state_q == ST_MOVE_BACK),
    .push_back_i (state_q == ST_BLOCKSTUN),
    .posx_o      (posx_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      frame_q    <= '0;
      posx_q     <= W'(X_INIT);
      hit_pend_q <= 1'b0;
    end else begin
      hit_pend_q <= hit_pend_d;
      if (tick_i) begin
        state_q <= state_d;
        frame_q <= frame_d;
        posx_q  <= posx_next;
      end
    end
  end

  assign posx_o          = posx_q;
  assign posy_o          = W'(POS_Y);
  assign current_state_o = state_q;
  assign state_frame_o   = frame_q;
  assign hitbox_valid_o  = (state_q == ST_ATK_ACTIVE);
  assign hitbox_x1_o     = posx_q + W'(HB_X1_OFF);
  assign hitbox_x2_o     = posx_q + W'(HB_X2_OFF);
  assign hitbox_y1_o     = W'(HB_Y1);
  assign hitbox_y2_o     = W'(HB_Y2);
  assign hurtbox_x1_o    = posx_q + W'(HU_X1_OFF);
  assign hurtbox_x2_o    = posx_q + W'(HU_X2_OFF);
  assign hurtbox_y1_o    = W'(POS_Y);
  assign hurtbox_y2_o    = W'(POS_Y + 150);

endmodule
`default_nettype wire
